dht11_sensor_responder: RTL and testbench
=========================================

Name: dht11_sensor_responder

Overview:
Sensor-side end of the DHT11 single-wire protocol. Used for FPGA emulation and for closed-loop benches of the host-side data receiver. Detects the host start pulse, then sends the response preamble and a 40-bit frame: humidity int/dec, temperature int/dec, checksum. The line is open-drain: the block only ever pulls it low or releases it.

Parameters:
TICKS_PER_US, 50, clk cycles per microsecond (50 MHz default).
START_MIN_US, 18000, minimum host low time accepted as a start.
RESP_DELAY_US, 30, wait after host release before the response.
RESP_LOW_US, 80, response low phase.
RESP_HIGH_US, 80, response high phase.
BIT_LOW_US, 50, low phase before each bit and end-of-frame low.
BIT0_HIGH_US, 26, high time encoding "0".
BIT1_HIGH_US, 70, high time encoding "1".
COOLDOWN_US, 1000, post-frame interval during which start pulses are ignored.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
dht11_data_in  input  1  sampled bus level (asynchronous to clk)
dht11_drive_low  output  1  1 = pull bus low, 0 = release (top-level tri-state: bus = drive_low ? 0 : z)
hum_int  input  8  humidity integer byte
hum_dec  input  8  humidity decimal byte
temp_int  input  8  temperature integer byte
temp_dec  input  8  temperature decimal byte
busy  output  1  high from start acceptance until the end of cooldown
frame_done  output  1  one-cycle pulse when the end-of-frame low is released

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On reset: drive_low=0, busy=0, frame_done=0, state IDLE, all counters 0.
- Input sync: dht11_data_in passes through a 2-FF synchronizer. All decisions use the synchronized value, so there are 2 cycles of detection latency.
- Timebase: a prescaler produces a 1 us tick every TICKS_PER_US cycles. Phase counters count us ticks. Each phase lasts exactly N*TICKS_PER_US cycles, within ±1 cycle of prescaler alignment; the prescaler is restarted at every phase entry.
- States:
  - IDLE: on a synchronized low, go to MEAS_LOW.
  - MEAS_LOW: count low time. If the line goes high before START_MIN_US, return to IDLE (glitch or short pulse ignored). Once the count reaches START_MIN_US, go to WAIT_REL.
  - WAIT_REL: on the first high sample, latch the four data bytes, compute checksum = (hum_int+hum_dec+temp_int+temp_dec) mod 256, set busy=1, go to RESP_DELAY. Bytes changing later do not affect the frame in flight.
  - RESP_DELAY: drive_low=0 for RESP_DELAY_US.
  - RESP_LOW: drive_low=1 for RESP_LOW_US.
  - RESP_HIGH: drive_low=0 for RESP_HIGH_US.
  - BIT_LOW: drive_low=1 for BIT_LOW_US.
  - BIT_HIGH: drive_low=0 for BIT1_HIGH_US if the current bit is 1, else BIT0_HIGH_US. Bit order is MSB first: hum_int[7] first, checksum[0] last. A 6-bit index runs 0..39. After bit 39, go to END_LOW; otherwise go to BIT_LOW with index+1.
  - END_LOW: drive_low=1 for BIT_LOW_US, then release, pulse frame_done, go to COOLDOWN.
  - COOLDOWN: drive_low=0 and the line is ignored for COOLDOWN_US, then busy=0 and go to IDLE.
- The input line is not monitored while in RESP_DELAY..COOLDOWN.
- Reset mid-frame: next edge releases the line and returns to IDLE. No frame_done.
- The line already low at reset release is treated as a start beginning at that cycle.
- A zero-valued timing parameter is illegal and unsupported.

Optional Feature:
DHT11_ERR_INJECT_EN.
- Defined: adds port inject_err (input, 1), sampled together with the data bytes in WAIT_REL. If it is 1, the transmitted checksum is (computed sum XOR 8'h01).
- Undefined: port absent, checksum always correct.

Test Plan:
- Nominal: bytes 0x37,0x00,0x19,0x05 (checksum 0x55); host low 18 ms then release → response low 80 us / high 80 us, 40 bits decoded 0x37_00_19_05_55, frame_done pulse 50 us after the last bit high, busy low 1000 us later.
- Short pulse: host low 10 ms then release → drive_low stays 0, busy stays 0, state returns to IDLE.
- Checksum wrap: bytes 0xFF,0xFF,0x01,0x02 → checksum 0x01; bit-1 highs measure 3500 cycles, bit-0 highs 1300 cycles at 50 MHz.
- Reset mid-frame: assert rst during bit 20 → drive_low=0 next cycle, no frame_done; a subsequent valid start produces a full frame.
- Cooldown: a second 18 ms start issued 200 us after frame_done is ignored; the same start issued after busy falls is answered.
- With DHT11_ERR_INJECT_EN, inject_err=1, bytes 0x37,0x00,0x19,0x05 → checksum sent 0x54.

Source files
------------

// File: rtl/dht11_sensor_responder.sv
// DHT11 sensor-side responder: detects the host start pulse, then sends the response preamble and a 40-bit frame.
// Optional DHT11_ERR_INJECT_EN adds inject_err, which flips checksum bit 0 of the latched frame.
module dht11_sensor_responder #(
  parameter int TICKS_PER_US  = 50,
  parameter int START_MIN_US  = 18000,
  parameter int RESP_DELAY_US = 30,
  parameter int RESP_LOW_US   = 80,
  parameter int RESP_HIGH_US  = 80,
  parameter int BIT_LOW_US    = 50,
  parameter int BIT0_HIGH_US  = 26,
  parameter int BIT1_HIGH_US  = 70,
  parameter int COOLDOWN_US   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dht11_data_in,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  output logic       dht11_drive_low,
  output logic       busy,
  output logic       frame_done
`ifdef DHT11_ERR_INJECT_EN
  , input logic      inject_err
`endif
);

  typedef enum logic [3:0] {
    IDLE, MEAS_LOW, WAIT_REL, RESP_DELAY, RESP_LOW,
    RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW, COOLDOWN
  } state_t;

  localparam logic [15:0] PRE_LOAD = 16'(TICKS_PER_US - 1);

  function automatic logic [15:0] phase_len(input int us);
    return 16'(us - 1);
  endfunction

  state_t      state;
  logic [1:0]  sync;
  logic        line_s;
  logic [15:0] pre_cnt;
  logic [15:0] us_cnt;
  logic        tick;
  logic        phase_done;
  logic [39:0] frame_sr;
  logic [5:0]  bit_idx;
  logic [7:0]  checksum;

  assign line_s     = sync[1];
  assign tick       = (pre_cnt == '0);
  assign phase_done = tick && (us_cnt == '0);

  always_comb begin
    checksum = hum_int + hum_dec + temp_int + temp_dec;
`ifdef DHT11_ERR_INJECT_EN
    if (inject_err) checksum = checksum ^ 8'h01;
`endif
  end

  // Each phase reloads both down-counters so it lasts exactly N * TICKS_PER_US cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      sync            <= 2'b11;
      pre_cnt         <= '0;
      us_cnt          <= '0;
      frame_sr        <= '0;
      bit_idx         <= '0;
      dht11_drive_low <= 1'b0;
      busy            <= 1'b0;
      frame_done      <= 1'b0;
    end else begin
      sync       <= {sync[0], dht11_data_in};
      frame_done <= 1'b0;
      if (tick) begin
        pre_cnt <= PRE_LOAD;
        if (us_cnt != '0) us_cnt <= us_cnt - 16'd1;
      end else begin
        pre_cnt <= pre_cnt - 16'd1;
      end

      case (state)
        IDLE: if (!line_s) begin
          state   <= MEAS_LOW;
          pre_cnt <= PRE_LOAD;
          us_cnt  <= phase_len(START_MIN_US);
        end
        MEAS_LOW: begin
          if (line_s) state <= IDLE;
          else if (phase_done) state <= WAIT_REL;
        end
        WAIT_REL: if (line_s) begin
          frame_sr <= {hum_int, hum_dec, temp_int, temp_dec, checksum};
          bit_idx  <= '0;
          busy     <= 1'b1;
          state    <= RESP_DELAY;
          pre_cnt  <= PRE_LOAD;
          us_cnt   <= phase_len(RESP_DELAY_US);
        end
        RESP_DELAY: if (phase_done) begin
          state           <= RESP_LOW;
          dht11_drive_low <= 1'b1;
          pre_cnt         <= PRE_LOAD;
          us_cnt          <= phase_len(RESP_LOW_US);
        end
        RESP_LOW: if (phase_done) begin
          state           <= RESP_HIGH;
          dht11_drive_low <= 1'b0;
          pre_cnt         <= PRE_LOAD;
          us_cnt          <= phase_len(RESP_HIGH_US);
        end
        RESP_HIGH: if (phase_done) begin
          state           <= BIT_LOW;
          dht11_drive_low <= 1'b1;
          pre_cnt         <= PRE_LOAD;
          us_cnt          <= phase_len(BIT_LOW_US);
        end
        BIT_LOW: if (phase_done) begin
          state           <= BIT_HIGH;
          dht11_drive_low <= 1'b0;
          pre_cnt         <= PRE_LOAD;
          us_cnt          <= frame_sr[39] ? phase_len(BIT1_HIGH_US) : phase_len(BIT0_HIGH_US);
        end
        BIT_HIGH: if (phase_done) begin
          dht11_drive_low <= 1'b1;
          pre_cnt         <= PRE_LOAD;
          us_cnt          <= phase_len(BIT_LOW_US);
          if (bit_idx == 6'd39) begin
            state <= END_LOW;
          end else begin
            state    <= BIT_LOW;
            bit_idx  <= bit_idx + 6'd1;
            frame_sr <= {frame_sr[38:0], 1'b0};
          end
        end
        END_LOW: if (phase_done) begin
          state           <= COOLDOWN;
          dht11_drive_low <= 1'b0;
          frame_done      <= 1'b1;
          pre_cnt         <= PRE_LOAD;
          us_cnt          <= phase_len(COOLDOWN_US);
        end
        COOLDOWN: if (phase_done) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state           <= IDLE;
          dht11_drive_low <= 1'b0;
          busy            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_sensor_responder.sv
// Directed bench for dht11_sensor_responder with scaled timing (2 clk per us, short start/cooldown).
module tb_dht11_sensor_responder;

  localparam int TPU = 2;
  localparam int RLOW_CYC  = 160;
  localparam int RHIGH_CYC = 160;
  localparam int BLOW_CYC  = 100;
  localparam int B0_CYC    = 52;
  localparam int B1_CYC    = 140;
  localparam int COOL_CYC  = 600;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_low = 1'b0;
  logic       data_in;
  logic       drive_low;
  logic       busy;
  logic       frame_done;
  logic [7:0] hum_int = 8'h00;
  logic [7:0] hum_dec = 8'h00;
  logic [7:0] temp_int = 8'h00;
  logic [7:0] temp_dec = 8'h00;
`ifdef DHT11_ERR_INJECT_EN
  logic       inject_err = 1'b0;
`endif

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  assign data_in = ~(host_low | drive_low);

  dht11_sensor_responder #(
    .TICKS_PER_US(TPU), .START_MIN_US(100), .RESP_DELAY_US(30), .RESP_LOW_US(80),
    .RESP_HIGH_US(80), .BIT_LOW_US(50), .BIT0_HIGH_US(26), .BIT1_HIGH_US(70),
    .COOLDOWN_US(300)
  ) dut (
    .clk(clk), .rst(rst), .dht11_data_in(data_in),
    .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
    .dht11_drive_low(drive_low), .busy(busy), .frame_done(frame_done)
`ifdef DHT11_ERR_INJECT_EN
    , .inject_err(inject_err)
`endif
  );

  task automatic host_start(input int cycles);
    host_low = 1'b1;
    repeat (cycles) @(negedge clk);
    host_low = 1'b0;
  endtask

  task automatic measure(input logic lvl, input int limit, output int len);
    len = 0;
    while (drive_low === lvl && len < limit) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic set_bytes(input logic [31:0] b);
    {hum_int, hum_dec, temp_int, temp_dec} = b;
  endtask

  task automatic receive_frame(input int wmin, input int wmax, output logic [39:0] data,
                               output int h1min, output int h1max, output int h0min, output int h0max);
    int len;
    int bad_low;
    data = '0; bad_low = 0;
    h1min = 100000; h1max = 0; h0min = 100000; h0max = 0;
    measure(1'b0, 1000, len);
    total++;
    if (len < wmin || len > wmax) $display("FAIL resp_delay: got %0d cycles, want %0d..%0d", len, wmin, wmax);
    else passes++;
    measure(1'b1, 1000, len);
    total++;
    if (len !== RLOW_CYC) $display("FAIL resp_low: got %0d cycles, want %0d", len, RLOW_CYC);
    else passes++;
    total++;
    if (busy !== 1'b1) $display("FAIL busy_in_frame: got %b, want 1", busy);
    else passes++;
    measure(1'b0, 1000, len);
    total++;
    if (len !== RHIGH_CYC) $display("FAIL resp_high: got %0d cycles, want %0d", len, RHIGH_CYC);
    else passes++;
    for (int i = 0; i < 40; i++) begin
      measure(1'b1, 1000, len);
      if (len != BLOW_CYC) bad_low++;
      measure(1'b0, 1000, len);
      if (len > 96) begin
        data = {data[38:0], 1'b1};
        if (len < h1min) h1min = len;
        if (len > h1max) h1max = len;
      end else begin
        data = {data[38:0], 1'b0};
        if (len < h0min) h0min = len;
        if (len > h0max) h0max = len;
      end
    end
    total++;
    if (bad_low !== 0) $display("FAIL bit_low: %0d bit lows differ from %0d cycles, want 0", bad_low, BLOW_CYC);
    else passes++;
    measure(1'b1, 1000, len);
    total++;
    if (len !== BLOW_CYC) $display("FAIL end_low: got %0d cycles, want %0d", len, BLOW_CYC);
    else passes++;
    total++;
    if (frame_done !== 1'b1) $display("FAIL frame_done_pulse: got %b, want 1", frame_done);
    else passes++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      n++;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic check_data(input string name, input logic [39:0] got, input logic [39:0] want);
    total++;
    if (got !== want) $display("FAIL %s: got %h, want %h", name, got, want);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (drive_low !== 1'b0) $display("FAIL reset_drive: got %b, want 0", drive_low);
    else passes++;
    total++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b, want 0", busy);
    else passes++;
    total++;
    if (frame_done !== 1'b0) $display("FAIL reset_done: got %b, want 0", frame_done);
    else passes++;
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_nominal();
    logic [39:0] d;
    int a, b, c, e, cnt;
    set_bytes(32'h37001905);
    host_start(250);
    repeat (5) @(negedge clk);
    set_bytes(32'hAABBCCDD);
    receive_frame(57, 59, d, a, b, c, e);
    check_data("nominal_frame", d, 40'h3700190555);
    @(negedge clk);
    total++;
    if (frame_done !== 1'b0) $display("FAIL frame_done_width: got %b, want 0", frame_done);
    else passes++;
    cnt = 1;
    while (busy === 1'b1 && cnt < 2000) begin
      cnt++;
      @(negedge clk);
    end
    total++;
    if (cnt !== COOL_CYC) $display("FAIL cooldown_len: got %0d cycles, want %0d", cnt, COOL_CYC);
    else passes++;
    wait_idle();
  endtask

  task automatic test_short_pulse();
    int saw_drive, saw_busy;
    saw_drive = 0; saw_busy = 0;
    set_bytes(32'h37001905);
    host_start(120);
    for (int i = 0; i < 1000; i++) begin
      if (drive_low === 1'b1) saw_drive++;
      if (busy === 1'b1) saw_busy++;
      @(negedge clk);
    end
    total++;
    if (saw_drive !== 0) $display("FAIL short_drive: drive_low high for %0d cycles, want 0", saw_drive);
    else passes++;
    total++;
    if (saw_busy !== 0) $display("FAIL short_busy: busy high for %0d cycles, want 0", saw_busy);
    else passes++;
  endtask

  task automatic test_checksum_wrap();
    logic [39:0] d;
    int h1min, h1max, h0min, h0max;
    set_bytes(32'hFFFF0102);
    host_start(250);
    receive_frame(62, 64, d, h1min, h1max, h0min, h0max);
    check_data("wrap_frame", d, 40'hFFFF010201);
    total++;
    if (h1min !== B1_CYC || h1max !== B1_CYC) $display("FAIL bit1_high: got %0d..%0d, want %0d", h1min, h1max, B1_CYC);
    else passes++;
    total++;
    if (h0min !== B0_CYC || h0max !== B0_CYC) $display("FAIL bit0_high: got %0d..%0d, want %0d", h0min, h0max, B0_CYC);
    else passes++;
    wait_idle();
  endtask

  task automatic test_reset_mid_frame();
    logic [39:0] d;
    int len, a, b, c, e, saw_done, saw_drive;
    set_bytes(32'h5AC3010F);
    host_start(250);
    measure(1'b0, 1000, len);
    measure(1'b1, 1000, len);
    measure(1'b0, 1000, len);
    for (int i = 0; i < 20; i++) begin
      measure(1'b1, 1000, len);
      measure(1'b0, 1000, len);
    end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (drive_low !== 1'b0) $display("FAIL midreset_drive: got %b, want 0", drive_low);
    else passes++;
    total++;
    if (busy !== 1'b0) $display("FAIL midreset_busy: got %b, want 0", busy);
    else passes++;
    rst = 1'b0;
    saw_done = 0; saw_drive = 0;
    for (int i = 0; i < 1500; i++) begin
      if (frame_done === 1'b1) saw_done++;
      if (drive_low === 1'b1) saw_drive++;
      @(negedge clk);
    end
    total++;
    if (saw_done !== 0 || saw_drive !== 0)
      $display("FAIL midreset_quiet: frame_done %0d / drive_low %0d cycles, want 0 / 0", saw_done, saw_drive);
    else passes++;
    host_start(250);
    receive_frame(62, 64, d, a, b, c, e);
    check_data("post_reset_frame", d, 40'h5AC3010F2D);
    wait_idle();
  endtask

  task automatic test_cooldown();
    logic [39:0] d;
    int a, b, c, e, saw_drive;
    set_bytes(32'h12345678);
    host_start(250);
    receive_frame(62, 64, d, a, b, c, e);
    check_data("cool_first_frame", d, 40'h1234567814);
    repeat (400) @(negedge clk);
    host_start(250);
    saw_drive = 0;
    for (int i = 0; i < 1000; i++) begin
      if (drive_low === 1'b1) saw_drive++;
      @(negedge clk);
    end
    total++;
    if (saw_drive !== 0) $display("FAIL cooldown_ignore: drive_low high for %0d cycles, want 0", saw_drive);
    else passes++;
    total++;
    if (busy !== 1'b0) $display("FAIL cooldown_busy: got %b, want 0", busy);
    else passes++;
    host_start(250);
    receive_frame(62, 64, d, a, b, c, e);
    check_data("cool_second_frame", d, 40'h1234567814);
    wait_idle();
  endtask

`ifdef DHT11_ERR_INJECT_EN
  task automatic test_err_inject();
    logic [39:0] d;
    int a, b, c, e;
    set_bytes(32'h37001905);
    inject_err = 1'b1;
    host_start(250);
    repeat (5) @(negedge clk);
    inject_err = 1'b0;
    receive_frame(57, 59, d, a, b, c, e);
    check_data("inject_frame", d, 40'h3700190554);
    wait_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_short_pulse();
    test_checksum_wrap();
    test_reset_mid_frame();
    test_cooldown();
`ifdef DHT11_ERR_INJECT_EN
    test_err_inject();
`endif
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
